// File: rtl/maze_pkg.sv
// Shared definitions for the maze keyboard front end: command codes, HID usages,
// FSM state encoding and the single-byte usage-to-command map.
package maze_pkg;

    localparam logic [2:0] CMD_NONE   = 3'd0;
    localparam logic [2:0] CMD_UP     = 3'd1;
    localparam logic [2:0] CMD_DOWN   = 3'd2;
    localparam logic [2:0] CMD_LEFT   = 3'd3;
    localparam logic [2:0] CMD_RIGHT  = 3'd4;
    localparam logic [2:0] CMD_SELECT = 3'd5;

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_ENTER = 8'h28;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2,
        ST_LATCH  = 2'd3
    } state_t;

    function automatic logic [2:0] map_usage(input logic [7:0] usage);
        case (usage)
            KEY_W, KEY_UP:       map_usage = CMD_UP;
            KEY_S, KEY_DOWN:     map_usage = CMD_DOWN;
            KEY_A, KEY_LEFT:     map_usage = CMD_LEFT;
            KEY_D, KEY_RIGHT:    map_usage = CMD_RIGHT;
            KEY_ENTER:           map_usage = CMD_SELECT;
            default:             map_usage = CMD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/maze_key_decoder.sv
// Combinational key_code decoder: the primary usage byte wins whenever it maps,
// otherwise the secondary byte is tried.
module maze_key_decoder
    import maze_pkg::*;
(
    input  logic [15:0] key_code,
    output logic [2:0]  cmd
);

    logic [2:0] primary_cmd;
    logic [2:0] secondary_cmd;

    assign primary_cmd   = map_usage(key_code[7:0]);
    assign secondary_cmd = map_usage(key_code[15:8]);
    assign cmd           = (primary_cmd != CMD_NONE) ? primary_cmd : secondary_cmd;

endmodule

// File: rtl/maze_key_cmd_gen.sv
// Turns the Nios key_code word into maze commands with press detection,
// hold auto-repeat and a one-entry valid/ready output register.
module maze_key_cmd_gen
    import maze_pkg::*;
#(
    parameter int REPEAT_DELAY  = 20_000_000,
    parameter int REPEAT_PERIOD = 5_000_000,
    parameter int CNT_W         = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] key_code,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [2:0]  cmd,
    output logic        key_held,
    output logic [7:0]  drop_count
);

    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [15:0]      key_q;
    logic [2:0]       decoded;
    state_t           state;
    state_t           state_nxt;
    state_t           held_state;
    logic [2:0]       cur_cmd;
    logic [2:0]       cur_cmd_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             emit;
    logic             emit_press;

    maze_key_decoder u_decoder (
        .key_code (key_q),
        .cmd      (decoded)
    );

    // A press (new key from IDLE or a change of key) always emits and restarts the hold timing.
    always_comb begin
        state_nxt   = state;
        cur_cmd_nxt = cur_cmd;
        cnt_nxt     = cnt;
        emit        = 1'b0;
        emit_press  = 1'b0;
        held_state  = (decoded == CMD_SELECT) ? ST_LATCH : ST_DELAY;

        if (state == ST_IDLE) begin
            if (decoded != CMD_NONE) begin
                emit        = 1'b1;
                emit_press  = 1'b1;
                cur_cmd_nxt = decoded;
                cnt_nxt     = '0;
                state_nxt   = held_state;
            end
        end else if (decoded == CMD_NONE) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else if (decoded != cur_cmd) begin
            emit        = 1'b1;
            emit_press  = 1'b1;
            cur_cmd_nxt = decoded;
            cnt_nxt     = '0;
            state_nxt   = held_state;
        end else begin
            case (state)
                ST_DELAY: begin
                    if (cnt == DELAY_LAST) begin
                        emit      = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = ST_REPEAT;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (cnt == PERIOD_LAST) begin
                        emit    = 1'b1;
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ST_LATCH: begin
                    cnt_nxt = '0;
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Blocked emits are counted as drops; only presses overwrite the pending command.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_q      <= '0;
            state      <= ST_IDLE;
            cur_cmd    <= CMD_NONE;
            cnt        <= '0;
            key_held   <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd        <= CMD_NONE;
            drop_count <= '0;
        end else begin
            key_q    <= key_code;
            state    <= state_nxt;
            cur_cmd  <= cur_cmd_nxt;
            cnt      <= cnt_nxt;
            key_held <= (decoded != CMD_NONE);

            if (emit && (!cmd_valid || cmd_ready)) begin
                cmd       <= decoded;
                cmd_valid <= 1'b1;
            end else if (emit) begin
                if (emit_press) begin
                    cmd <= decoded;
                end
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end else if (cmd_ready) begin
                cmd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_maze_key_cmd_gen.sv
// Self-checking bench for maze_key_cmd_gen with a hold-age based reference model.
module tb_maze_key_cmd_gen;

    localparam int D = 8;
    localparam int P = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] key_code;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd;
    logic        key_held;
    logic [7:0]  drop_count;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: keyq is the one-cycle input delay, run/age describe how long the current key has been held.
    logic [15:0] m_keyq;
    int          m_run;
    int          m_age;
    logic        m_valid;
    logic [2:0]  m_cmd;
    logic [7:0]  m_drop;
    logic        m_held;
    int          key_map[256];

    maze_key_cmd_gen #(
        .REPEAT_DELAY  (D),
        .REPEAT_PERIOD (P),
        .CNT_W         (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_code   (key_code),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd        (cmd),
        .key_held   (key_held),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    function automatic int dec16(input logic [15:0] k);
        int p;
        p = key_map[k[7:0]];
        return (p != 0) ? p : key_map[k[15:8]];
    endfunction

    task automatic model_edge(input logic [15:0] k, input logic r, input logic rst);
        int  d;
        bit  emit;
        bit  press;
        if (rst) begin
            m_keyq = '0; m_run = 0; m_age = 0; m_valid = 0; m_cmd = 0; m_drop = 0; m_held = 0;
            return;
        end
        d = dec16(m_keyq);
        emit = 0;
        press = 0;
        if (d == 0) begin
            m_run = 0;
        end else if (d != m_run) begin
            emit = 1; press = 1; m_run = d; m_age = 0;
        end else begin
            m_age++;
            if (d != 5 && m_age >= D && ((m_age - D) % P) == 0) emit = 1;
        end
        if (emit && (!m_valid || r)) begin
            m_cmd = 3'(d); m_valid = 1;
        end else if (emit) begin
            if (press) m_cmd = 3'(d);
            if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
        end else if (r) begin
            m_valid = 0;
        end
        m_held = (d != 0);
        m_keyq = k;
    endtask

    task automatic applyStimulus(input logic [15:0] k, input logic r, input logic rst);
        key_code  = k;
        cmd_ready = r;
        reset     = rst;
        @(posedge clk);
        model_edge(k, r, rst);
        #1;
    endtask

    task automatic test_reset();
        applyStimulus(16'h001A, 1'b1, 1'b1);
        applyStimulus(16'h0000, 1'b1, 1'b1);
        vectors++;
        if (cmd_valid !== 1'b0 || cmd !== 3'd0 || key_held !== 1'b0 || drop_count !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL reset: valid=%b cmd=%0d held=%b drop=%0d, expected all zero",
                     cmd_valid, cmd, key_held, drop_count);
        end
    endtask

    task automatic test_press_release();
        int pulses = 0;
        int first_t = -1;
        applyStimulus(16'h0000, 1'b1, 1'b0);
        applyStimulus(16'h0000, 1'b1, 1'b0);
        for (int t = 1; t <= 9; t++) begin
            applyStimulus((t <= 3) ? 16'h001A : 16'h0000, 1'b1, 1'b0);
            vectors++;
            if (cmd_valid !== m_valid || key_held !== m_held || drop_count !== m_drop || (m_valid && cmd !== m_cmd)) begin
                miscompares++;
                $display("[TB] FAIL press t=%0d: valid=%b held=%b cmd=%0d drop=%0d, expected %b %b %0d %0d",
                         t, cmd_valid, key_held, cmd, drop_count, m_valid, m_held, m_cmd, m_drop);
            end
            if (cmd_valid === 1'b1) begin
                pulses++;
                if (first_t < 0) first_t = t;
            end
        end
        vectors++;
        if (pulses != 1 || first_t != 2) begin
            miscompares++;
            $display("[TB] FAIL press_pulse: pulses=%0d at t=%0d, expected 1 at t=2", pulses, first_t);
        end
    endtask

    task automatic test_hold_repeat();
        int seen[$];
        int want[$] = '{2, 10, 14, 18, 22, 26, 30};
        applyStimulus(16'h0000, 1'b1, 1'b1);
        for (int t = 1; t <= 36; t++) begin
            applyStimulus((t <= 30) ? 16'h0050 : 16'h0000, 1'b1, 1'b0);
            vectors++;
            if (cmd_valid !== m_valid || key_held !== m_held || drop_count !== m_drop || (m_valid && cmd !== m_cmd)) begin
                miscompares++;
                $display("[TB] FAIL hold t=%0d: valid=%b held=%b cmd=%0d drop=%0d, expected %b %b %0d %0d",
                         t, cmd_valid, key_held, cmd, drop_count, m_valid, m_held, m_cmd, m_drop);
            end
            if (cmd_valid === 1'b1 && cmd === 3'd3) seen.push_back(t);
        end
        vectors++;
        if (seen != want) begin
            miscompares++;
            $display("[TB] FAIL hold_times: got %p, expected %p", seen, want);
        end
    endtask

    task automatic test_priority_change();
        logic [15:0] seq[3] = '{16'h4F04, 16'h4F00, 16'h1234};
        int          len[3] = '{4, 12, 4};
        applyStimulus(16'h0000, 1'b1, 1'b1);
        foreach (seq[s]) begin
            for (int t = 1; t <= len[s]; t++) begin
                applyStimulus(seq[s], 1'b1, 1'b0);
                vectors++;
                if (cmd_valid !== m_valid || key_held !== m_held || drop_count !== m_drop || (m_valid && cmd !== m_cmd)) begin
                    miscompares++;
                    $display("[TB] FAIL priority key=%h t=%0d: valid=%b held=%b cmd=%0d, expected %b %b %0d",
                             seq[s], t, cmd_valid, key_held, cmd, m_valid, m_held, m_cmd);
                end
                if (s == 1 && t == 2) begin
                    vectors++;
                    if (cmd_valid !== 1'b1 || cmd !== 3'd4) begin
                        miscompares++;
                        $display("[TB] FAIL priority_change: valid=%b cmd=%0d, expected 1 4", cmd_valid, cmd);
                    end
                end
            end
        end
        vectors++;
        if (key_held !== 1'b0 || cmd_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL unmapped: held=%b valid=%b, expected 0 0", key_held, cmd_valid);
        end
    endtask

    task automatic test_backpressure();
        applyStimulus(16'h0000, 1'b1, 1'b1);
        for (int t = 1; t <= 23; t++) begin
            applyStimulus((t <= 20) ? 16'h0016 : 16'h0000, 1'b0, 1'b0);
            vectors++;
            if (cmd_valid !== m_valid || key_held !== m_held || drop_count !== m_drop || (m_valid && cmd !== m_cmd)) begin
                miscompares++;
                $display("[TB] FAIL backpressure t=%0d: valid=%b cmd=%0d drop=%0d, expected %b %0d %0d",
                         t, cmd_valid, cmd, drop_count, m_valid, m_cmd, m_drop);
            end
        end
        vectors++;
        if (cmd_valid !== 1'b1 || cmd !== 3'd2 || drop_count !== 8'd3) begin
            miscompares++;
            $display("[TB] FAIL backpressure_hold: valid=%b cmd=%0d drop=%0d, expected 1 2 3", cmd_valid, cmd, drop_count);
        end
        applyStimulus(16'h0000, 1'b1, 1'b0);
        vectors++;
        if (cmd_valid !== 1'b0 || drop_count !== 8'd3) begin
            miscompares++;
            $display("[TB] FAIL backpressure_release: valid=%b drop=%0d, expected 0 3", cmd_valid, drop_count);
        end
    endtask

    task automatic test_overwrite_select();
        int transfers = 0;
        applyStimulus(16'h0000, 1'b1, 1'b1);
        for (int t = 1; t <= 7; t++) begin
            applyStimulus((t <= 3) ? 16'h0007 : 16'h0028, 1'b0, 1'b0);
            vectors++;
            if (cmd_valid !== m_valid || key_held !== m_held || drop_count !== m_drop || (m_valid && cmd !== m_cmd)) begin
                miscompares++;
                $display("[TB] FAIL overwrite t=%0d: valid=%b cmd=%0d drop=%0d, expected %b %0d %0d",
                         t, cmd_valid, cmd, drop_count, m_valid, m_cmd, m_drop);
            end
        end
        vectors++;
        if (cmd_valid !== 1'b1 || cmd !== 3'd5 || drop_count !== 8'd1) begin
            miscompares++;
            $display("[TB] FAIL overwrite_result: valid=%b cmd=%0d drop=%0d, expected 1 5 1", cmd_valid, cmd, drop_count);
        end
        for (int t = 1; t <= 40; t++) begin
            if (cmd_valid === 1'b1) transfers++;
            applyStimulus(16'h0028, 1'b1, 1'b0);
        end
        vectors++;
        if (transfers != 1) begin
            miscompares++;
            $display("[TB] FAIL select_latch: transfers=%0d, expected 1", transfers);
        end
    endtask

    task automatic test_reset_mid_repeat();
        applyStimulus(16'h0000, 1'b1, 1'b1);
        for (int t = 1; t <= 12; t++) applyStimulus(16'h001A, 1'b1, 1'b0);
        applyStimulus(16'h001A, 1'b1, 1'b1);
        vectors++;
        if (cmd_valid !== 1'b0 || cmd !== 3'd0 || key_held !== 1'b0 || drop_count !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset: valid=%b cmd=%0d held=%b drop=%0d, expected all zero",
                     cmd_valid, cmd, key_held, drop_count);
        end
        for (int t = 1; t <= 4; t++) begin
            applyStimulus(16'h001A, 1'b1, 1'b0);
            vectors++;
            if (cmd_valid !== (t == 2) || (t == 2 && cmd !== 3'd1) || cmd_valid !== m_valid) begin
                miscompares++;
                $display("[TB] FAIL post_reset t=%0d: valid=%b cmd=%0d, expected valid=%b cmd=1", t, cmd_valid, cmd, t == 2);
            end
        end
    endtask

    task automatic test_drop_saturate();
        applyStimulus(16'h0000, 1'b1, 1'b1);
        for (int t = 1; t <= 270; t++) applyStimulus(t[0] ? 16'h0004 : 16'h0007, 1'b0, 1'b0);
        vectors++;
        if (drop_count !== 8'hFF || drop_count !== m_drop) begin
            miscompares++;
            $display("[TB] FAIL drop_saturate: drop=%0d, expected 255", drop_count);
        end
    endtask

    task automatic test_random();
        logic [7:0] pool[12] = '{8'h00, 8'h1A, 8'h52, 8'h16, 8'h51, 8'h04, 8'h50, 8'h07, 8'h4F, 8'h28, 8'h12, 8'hFF};
        logic [15:0] k;
        int          hold;
        applyStimulus(16'h0000, 1'b1, 1'b1);
        for (int s = 0; s < 80; s++) begin
            k    = {pool[$urandom_range(0, 11)], pool[$urandom_range(0, 11)]};
            hold = $urandom_range(1, 20);
            for (int t = 0; t < hold; t++) begin
                applyStimulus(k, ($urandom_range(0, 3) != 0), 1'b0);
                vectors++;
                if (cmd_valid !== m_valid || key_held !== m_held || drop_count !== m_drop || (m_valid && cmd !== m_cmd)) begin
                    miscompares++;
                    $display("[TB] FAIL random key=%h: valid=%b held=%b cmd=%0d drop=%0d, expected %b %b %0d %0d",
                             k, cmd_valid, key_held, cmd, drop_count, m_valid, m_held, m_cmd, m_drop);
                end
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        key_code  = 16'h0000;
        cmd_ready = 1'b1;
        foreach (key_map[i]) key_map[i] = 0;
        key_map[8'h1A] = 1; key_map[8'h52] = 1;
        key_map[8'h16] = 2; key_map[8'h51] = 2;
        key_map[8'h04] = 3; key_map[8'h50] = 3;
        key_map[8'h07] = 4; key_map[8'h4F] = 4;
        key_map[8'h28] = 5;

        test_reset();
        test_press_release();
        test_hold_repeat();
        test_priority_change();
        test_backpressure();
        test_overwrite_select();
        test_reset_mid_repeat();
        test_drop_saturate();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
